// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds hCount/vCount/bright from raw sync
// pulses, verifies line/frame geometry and reports lock, errors and frame count.
module vga_sync_decoder #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515,
  parameter int LEN_W       = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hSync,
  input  logic       vSync,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic       frame_strobe,
  output logic [7:0] frame_cnt
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LINE_CLKS = LEN_W'(H_TOTAL * CLK_DIV);
  localparam logic [LEN_W-1:0] SYNC_CLKS = LEN_W'(H_SYNC * CLK_DIV);
  localparam logic [LEN_W-1:0] WD_CLKS   = LEN_W'(2 * H_TOTAL * CLK_DIV);
  localparam logic [LEN_W-1:0] WD_NEAR   = LEN_W'(2 * H_TOTAL * CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] V_SYN   = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_S = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_E = 10'(H_ACT_END);
  localparam logic [9:0] V_ACT_S = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_E = 10'(V_ACT_END);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic hs_meta_q, hs_meta_d, hs2_q, hs2_d, hs_prev_q, hs_prev_d;
  logic vs_meta_q, vs_meta_d, vs2_q, vs2_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [9:0]       hcount_q, hcount_d, vcount_q, vcount_d;
  logic [LEN_W-1:0] line_len_q, line_len_d;
  logic             len_valid_q, len_valid_d;
  logic             vs_line_q, vs_line_d;
  logic [9:0]       vlow_run_q, vlow_run_d;
  logic [9:0]       frame_lines_q, frame_lines_d;
  logic             frame_valid_q, frame_valid_d;
  logic [1:0]       state_q, state_d;
  logic             err_seen_q, err_seen_d;
  logic             h_err_q, h_err_d, v_err_q, v_err_d;
  logic             frame_strobe_q, frame_strobe_d;
  logic             bright_q, bright_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic hfall, hrise, tripped, pix_step, frame_start, locked_now, any_err;

  assign hfall       = hs_prev_q & ~hs2_q;
  assign hrise       = ~hs_prev_q & hs2_q;
  assign tripped     = (line_len_q == WD_CLKS);
  assign pix_step    = (ph_q == PH_LAST);
  assign frame_start = hfall & ~vs2_q & vs_line_q;
  assign locked_now  = (state_q == ST_LOCKED);
  assign any_err     = h_err_d | v_err_d;

  always_comb begin
    hs_meta_d = hSync;
    hs2_d     = hs_meta_q;
    hs_prev_d = hs2_q;
    vs_meta_d = vSync;
    vs2_d     = vs_meta_q;

    ph_d = hfall ? '0 : (pix_step ? '0 : ph_q + 1'b1);

    // Line length saturates at the watchdog limit; that state also freezes the counters.
    line_len_d  = line_len_q;
    len_valid_d = len_valid_q;
    if (hfall) begin
      line_len_d  = LEN_W'(1);
      len_valid_d = 1'b1;
    end else if (!tripped) begin
      line_len_d = line_len_q + 1'b1;
      if (line_len_q == WD_NEAR) len_valid_d = 1'b0;
    end

    h_err_d = (hfall & len_valid_q & (line_len_q != LINE_CLKS))
            | (hrise & ~tripped & (line_len_q != SYNC_CLKS))
            | (~hfall & (line_len_q == WD_NEAR));

    hcount_d = hcount_q;
    if (hfall) hcount_d = '0;
    else if (pix_step && !tripped) hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;

    vcount_d = vcount_q;
    if (frame_start) vcount_d = '0;
    else if (hfall) vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;

    vs_line_d     = hfall ? vs2_q : vs_line_q;
    vlow_run_d    = vlow_run_q;
    frame_lines_d = frame_lines_q;
    frame_valid_d = frame_valid_q | frame_start;
    if (hfall && !vs2_q) begin
      if (vs_line_q) vlow_run_d = 10'd1;
      else if (vlow_run_q != 10'h3FF) vlow_run_d = vlow_run_q + 1'b1;
    end
    if (frame_start) frame_lines_d = 10'd1;
    else if (hfall && frame_lines_q != 10'h3FF) frame_lines_d = frame_lines_q + 1'b1;

    v_err_d = (frame_start & frame_valid_q & (frame_lines_q != V_TOT))
            | (hfall & vs2_q & ~vs_line_q & (vlow_run_q != V_SYN));

    frame_strobe_d = frame_start;

    // An error in the same cycle as the qualifying frame start still blocks lock.
    state_d    = state_q;
    err_seen_d = err_seen_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (frame_start) begin
          state_d    = ST_CHECK;
          err_seen_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (frame_start) begin
          state_d    = (err_seen_q | any_err) ? ST_CHECK : ST_LOCKED;
          err_seen_d = 1'b0;
        end else if (any_err) begin
          err_seen_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (any_err) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase

    bright_d = locked_now
             & (hcount_q >= H_ACT_S) & (hcount_q < H_ACT_E)
             & (vcount_q >= V_ACT_S) & (vcount_q < V_ACT_E);

    frame_cnt_d = frame_cnt_q + {7'd0, frame_strobe_q & locked_now};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_meta_q      <= 1'b1;
      hs2_q          <= 1'b1;
      hs_prev_q      <= 1'b1;
      vs_meta_q      <= 1'b1;
      vs2_q          <= 1'b1;
      ph_q           <= '0;
      hcount_q       <= '0;
      vcount_q       <= '0;
      line_len_q     <= '0;
      len_valid_q    <= 1'b0;
      vs_line_q      <= 1'b1;
      vlow_run_q     <= '0;
      frame_lines_q  <= '0;
      frame_valid_q  <= 1'b0;
      state_q        <= ST_UNLOCKED;
      err_seen_q     <= 1'b0;
      h_err_q        <= 1'b0;
      v_err_q        <= 1'b0;
      frame_strobe_q <= 1'b0;
      bright_q       <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      hs_meta_q      <= hs_meta_d;
      hs2_q          <= hs2_d;
      hs_prev_q      <= hs_prev_d;
      vs_meta_q      <= vs_meta_d;
      vs2_q          <= vs2_d;
      ph_q           <= ph_d;
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      line_len_q     <= line_len_d;
      len_valid_q    <= len_valid_d;
      vs_line_q      <= vs_line_d;
      vlow_run_q     <= vlow_run_d;
      frame_lines_q  <= frame_lines_d;
      frame_valid_q  <= frame_valid_d;
      state_q        <= state_d;
      err_seen_q     <= err_seen_d;
      h_err_q        <= h_err_d;
      v_err_q        <= v_err_d;
      frame_strobe_q <= frame_strobe_d;
      bright_q       <= bright_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign hCount       = hcount_q;
  assign vCount       = vcount_q;
  assign bright       = bright_q;
  assign locked       = locked_now;
  assign h_err        = h_err_q;
  assign v_err        = v_err_q;
  assign frame_strobe = frame_strobe_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken 10x8-pixel frame so that
// hundreds of frames fit in a short run.
module tb_vga_sync_decoder;
  localparam int C   = 2;
  localparam int HT  = 10;
  localparam int HS  = 2;
  localparam int HAS = 3;
  localparam int HAE = 9;
  localparam int VT  = 8;
  localparam int VS  = 2;
  localparam int VAS = 2;
  localparam int VAE = 7;
  localparam int LW  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hSync = 1'b1;
  logic       vSync = 1'b1;
  logic [9:0] hCount, vCount;
  logic       bright, locked, h_err, v_err, frame_strobe;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .CLK_DIV(C), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .hSync(hSync), .vSync(vSync),
    .hCount(hCount), .vCount(vCount), .bright(bright), .locked(locked),
    .h_err(h_err), .v_err(v_err), .frame_strobe(frame_strobe), .frame_cnt(frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Event monitor sampled on the falling edge.
  int h_err_cnt = 0, v_err_cnt = 0, fs_cnt = 0;
  int herr_hcount = -1, verr_vcount = -1, locked_after_herr = -1;
  int bright_len = 0, bright_runs = 0, bright_bad = 0, bright_vline = 0;
  int strobe_lock[4];
  int strobe_prelock[4];
  bit herr_prev = 1'b0;
  bit prev_locked = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (herr_prev) locked_after_herr = locked;
      herr_prev = h_err;
      if (h_err) begin h_err_cnt++; herr_hcount = hCount; end
      if (v_err) begin v_err_cnt++; verr_vcount = vCount; end
      if (frame_strobe) begin
        if (fs_cnt < 4) begin
          strobe_lock[fs_cnt]    = locked;
          strobe_prelock[fs_cnt] = prev_locked;
        end
        fs_cnt++;
      end
      prev_locked = locked;
      if (bright) begin
        if (bright_len == 0) bright_vline = vCount;
        bright_len++;
      end else if (bright_len > 0) begin
        bright_runs++;
        if (bright_len != (HAE - HAS) * C || bright_vline < VAS || bright_vline >= VAE)
          bright_bad++;
        bright_len = 0;
      end
    end
  end

  task automatic drive_line(input int px, input int sync_px, input bit vlow, input bit chk);
    for (int i = 0; i < px * C; i++) begin
      @(negedge clk);
      if (chk) begin
        if (i == 2) check_eq("lat_pre_hcount", hCount, HT - 1);
        if (i == 3) begin
          check_eq("lat_hcount0", hCount, 0);
          check_eq("lat_vcount0", vCount, 0);
          check_eq("lat_fstrobe", frame_strobe, 1);
        end
        if (i == 4) check_eq("lat_hold", hCount, 0);
        if (i == 5) check_eq("lat_step", hCount, 1);
      end
      hSync = (i < sync_px * C) ? 1'b0 : 1'b1;
      vSync = ~vlow;
    end
  endtask

  task automatic drive_frame(input int vs_lines, input int short_line, input int narrow_line,
                             input bit chk);
    for (int l = 0; l < VT; l++)
      drive_line((l == short_line) ? HT - 1 : HT, (l == narrow_line) ? HS - 1 : HS,
                 l < vs_lines, chk && (l == 0));
  endtask

  task automatic nominal_frames(input int n);
    for (int f = 0; f < n; f++) drive_frame(VS, -1, -1, 1'b0);
  endtask

  int he0, ve0;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_counts", {hCount, vCount}, 0);
    check_eq("rst_flags", {bright, locked, h_err, v_err, frame_strobe, frame_cnt}, 0);
    rst = 1'b0;

    // Nominal lock-up over three frames
    nominal_frames(3);
    #1;
    check_eq("nom_fstrobes", fs_cnt, 3);
    check_eq("nom_lock_fs1", strobe_lock[0], 0);
    check_eq("nom_prelock_fs2", strobe_prelock[1], 0);
    check_eq("nom_lock_fs2", strobe_lock[1], 1);
    check_eq("nom_locked", locked, 1);
    check_eq("nom_frame_cnt", frame_cnt, 2);
    check_eq("nom_h_err", h_err_cnt, 0);
    check_eq("nom_v_err", v_err_cnt, 0);
    check_eq("nom_bright_runs", bright_runs, 10);
    check_eq("nom_bright_bad", bright_bad, 0);
    check_eq("nom_vcount_end", vCount, VT - 1);
    $display("phase nominal: checks=%0d", n_checks);

    // Latency on the next frame start, plus a short line 5 while locked
    he0 = h_err_cnt;
    drive_frame(VS, 5, -1, 1'b1);
    #1;
    check_eq("short_h_err", h_err_cnt - he0, 1);
    check_eq("short_lock_drop", locked_after_herr, 0);
    check_eq("short_frame_cnt", frame_cnt, 3);
    nominal_frames(1);
    #1;
    check_eq("short_check_state", locked, 0);
    nominal_frames(1);
    #1;
    check_eq("short_relock", locked, 1);
    check_eq("short_frame_cnt2", frame_cnt, 4);
    check_eq("short_no_more_h", h_err_cnt - he0, 1);
    $display("phase short line: checks=%0d", n_checks);

    // vSync low for three lines
    he0 = h_err_cnt; ve0 = v_err_cnt;
    drive_frame(3, -1, -1, 1'b0);
    #1;
    check_eq("vsw_v_err", v_err_cnt - ve0, 1);
    check_eq("vsw_vcount", verr_vcount, 3);
    check_eq("vsw_h_err", h_err_cnt - he0, 0);
    check_eq("vsw_locked", locked, 0);
    check_eq("vsw_frame_cnt", frame_cnt, 5);

    // Narrow hSync on line 4 while in CHECK restarts the check
    he0 = h_err_cnt;
    drive_frame(VS, -1, 4, 1'b0);
    #1;
    check_eq("hsw_h_err", h_err_cnt - he0, 1);
    check_eq("hsw_hcount", herr_hcount, 1);
    nominal_frames(1);
    #1;
    check_eq("hsw_restart", locked, 0);
    nominal_frames(1);
    #1;
    check_eq("hsw_relock", locked, 1);
    check_eq("hsw_frame_cnt", frame_cnt, 6);
    $display("phase sync width: checks=%0d", n_checks);

    // Loss of signal: hSync stays high for 100 clocks
    he0 = h_err_cnt; ve0 = v_err_cnt;
    repeat (100) @(negedge clk);
    #1;
    check_eq("los_h_err", h_err_cnt - he0, 1);
    check_eq("los_locked", locked, 0);
    check_eq("los_hcount_hold", hCount, HT - 1);
    check_eq("los_vcount_hold", vCount, VT - 1);
    he0 = h_err_cnt;
    nominal_frames(1);
    #1;
    check_eq("los_restart_h", h_err_cnt - he0, 0);
    check_eq("los_restart_v", v_err_cnt - ve0, 0);
    nominal_frames(1);
    #1;
    check_eq("los_relock", locked, 1);
    check_eq("los_frame_cnt", frame_cnt, 7);
    $display("phase loss of signal: checks=%0d", n_checks);

    // Reset in the middle of an active frame
    for (int l = 0; l < 4; l++) drive_line(HT, HS, l < VS, 1'b0);
    check_eq("mid_pre_cnt", frame_cnt, 8);
    @(negedge clk);
    hSync = 1'b1; vSync = 1'b1; rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_counts", {hCount, vCount}, 0);
    check_eq("mid_rst_flags", {bright, locked, h_err, v_err, frame_strobe, frame_cnt}, 0);
    rst = 1'b0;
    he0 = h_err_cnt; ve0 = v_err_cnt;
    for (int l = 4; l < VT; l++) drive_line(HT, HS, 1'b0, 1'b0);
    nominal_frames(1);
    #1;
    check_eq("mid_one_fs", locked, 0);
    nominal_frames(1);
    #1;
    check_eq("mid_relock", locked, 1);
    check_eq("mid_frame_cnt", frame_cnt, 1);
    check_eq("mid_h_err", h_err_cnt - he0, 0);
    check_eq("mid_v_err", v_err_cnt - ve0, 0);
    $display("phase reset mid-frame: checks=%0d", n_checks);

    // Frame counter wrap
    he0 = h_err_cnt; ve0 = v_err_cnt;
    nominal_frames(254);
    #1;
    check_eq("wrap_255", frame_cnt, 255);
    nominal_frames(1);
    #1;
    check_eq("wrap_0", frame_cnt, 0);
    nominal_frames(1);
    #1;
    check_eq("wrap_1", frame_cnt, 1);
    check_eq("wrap_errs", (h_err_cnt - he0) + (v_err_cnt - ve0), 0);
    check_eq("wrap_locked", locked, 1);
    $display("phase frame counter: checks=%0d", n_checks);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. Takes the raw active-low `hSync`/`vSync` pair, as driven to the connector, and recovers pixel coordinates and a `bright` window. It also checks line and frame geometry against the 640x480@60 timing and reports lock and error status. The team uses it as an on-board loopback checker and debug monitor alongside the display controller, all on the 100 MHz system clock.

## Interface
- `CLK_DIV`, 4: `clk` cycles per pixel.
- `H_TOTAL`, 800: pixels per line.
- `H_SYNC`, 96: `hSync` low width in pixels.
- `H_ACT_START`, 144: first active `hCount`.
- `H_ACT_END`, 784: first inactive `hCount` after the active region.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: `vSync` low width in lines.
- `V_ACT_START`, 35: first active `vCount`.
- `V_ACT_END`, 515: first inactive `vCount` after the active region.
- `LEN_W`, 13: width of the clk-cycle line-length counter. Must hold 2·H_TOTAL·CLK_DIV.
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `hSync`, in, 1: asynchronous, active-low horizontal sync.
- `vSync`, in, 1: asynchronous, active-low vertical sync.
- `hCount`, out, 10: recovered pixel column.
- `vCount`, out, 10: recovered line.
- `bright`, out, 1: recovered active-video window.
- `locked`, out, 1: geometry verified.
- `h_err`, out, 1: one-cycle pulse on any horizontal violation.
- `v_err`, out, 1: one-cycle pulse on any vertical violation.
- `frame_strobe`, out, 1: one-cycle pulse at each frame start.
- `frame_cnt`, out, 8: frames started while `locked`. Wraps at 255 to 0.

## Operation
- **Input synchronization**
  - `hSync` and `vSync` each pass through an identical two-flop synchronizer, giving `hs2`/`vs2`.
  - A third register per signal holds the previous value.
  - `hfall` = previous high and `hs2` low. `hrise` is the inverse.
- **Pixel phase** (`ph`, 0..CLK_DIV-1)
  - Cleared on `hfall`, otherwise increments and wraps.
  - A pixel step occurs when `ph` = CLK_DIV-1.
- **hCount**
  - Set to 0 on `hfall`.
  - On each pixel step it increments, wrapping from H_TOTAL-1 to 0 (freewheel).
- **Line start** (`hfall`)
  - Sample `vs2`.
  - If `vs2` is low and the previous line-start sample was high, this is a frame start: `vCount` goes to 0 and `frame_strobe` pulses.
  - Otherwise `vCount` increments, wrapping from V_TOTAL-1 to 0.
  - Sources must switch `vSync` no later than `hSync`.
- **Horizontal checks** (`h_err`)
  - `line_len` counts clk cycles since the last `hfall`.
  - On `hfall`, if `line_len` ≠ H_TOTAL·CLK_DIV, pulse `h_err`. Skipped for the first `hfall` after reset or after a timeout.
  - On `hrise`, if the low width ≠ H_SYNC·CLK_DIV, pulse `h_err`.
  - Watchdog: `line_len` reaching 2·H_TOTAL·CLK_DIV pulses `h_err` once and holds `line_len` there until the next `hfall`. While the watchdog is tripped, `hCount`/`vCount` hold.
- **Vertical checks** (`v_err`)
  - At frame start, if the lines since the previous frame start ≠ V_TOTAL, pulse `v_err`. Skipped for the first frame.
  - At the first line start with `vs2` high after a low run, if the run length ≠ V_SYNC, pulse `v_err`.
- **Lock FSM**
  - UNLOCKED → CHECK on frame start.
  - CHECK → LOCKED on the next frame start if no `h_err`/`v_err` occurred since entering CHECK. An error in CHECK restarts CHECK at the next frame start.
  - LOCKED → UNLOCKED on any `h_err` or `v_err`.
  - `locked` = 1 only in LOCKED.
- **Outputs**
  - `bright` = `locked` AND H_ACT_START ≤ `hCount` < H_ACT_END AND V_ACT_START ≤ `vCount` < V_ACT_END, registered.
  - `frame_cnt` increments on `frame_strobe` when `locked` is 1 at that cycle, including the transition cycle into LOCKED.

## Timing
- **Reset:** all outputs 0, FSM UNLOCKED, `ph` = 0, synchronizer flops 1 (idle-high sync). `rst` mid-frame aborts everything; re-lock needs two fresh frame starts.
- **hSync latency:** `hCount` reads 0 after the 3rd `clk` edge that samples `hSync` low, then holds each value for CLK_DIV cycles.
- **Other latencies:**
  - `h_err`/`v_err`/`frame_strobe`: same cycle that `hCount`/`vCount` update.
  - `bright`: one cycle after `hCount`/`vCount`.
  - `locked`: rises in the cycle after the second clean frame start.
- **Simultaneous events:** an error on the same cycle as the CHECK→LOCKED frame start keeps the FSM in CHECK.

## Test plan
- **Nominal:** feed a 640x480 stream (800×525 px, CLK_DIV = 4) from reset → `locked` = 1 after the second frame start, `bright` high for exactly 640 consecutive pixels (2560 clk) on lines 35–514, no errors for 3 frames, `frame_cnt` = 2 after the third frame start.
- **Short line:** one line of 799 px while locked → `h_err` single pulse at the following `hfall`, `locked` drops next cycle, relocks after two further clean frames.
- **Sync width:** a frame with `vSync` low for 3 lines → `v_err` pulse at the line after `vSync` returns high. Separately, an `hSync` low of 95 px → `h_err` pulse on `hrise`.
- **Loss of signal:** `hSync` held high 6400 clk → exactly one `h_err` pulse, `locked` = 0, counters hold. On restart, the first `hfall` produces no `h_err`.
- **Reset mid-frame:** assert `rst` at line 200 → all outputs 0 next cycle, `locked` returns only after two frame starts.
- **Frame counter:** 258 locked frames → `frame_cnt` wraps 255 → 0, ending at 1.
